// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : handshaked WIDTH-bit ALU, single-cycle ops plus shift-add multiply
// Revision: 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_neg,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam logic [SHW:0]   CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]   CNT_ONE  = (SHW+1)'(1);
  localparam logic [WIDTH:0] SUB_ONE  = (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW:0]         cnt_q, cnt_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic                 borrow;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic [SHW-1:0]       shamt;
  logic                 sh_in_range;
  logic [WIDTH-1:0]     sra_res;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic                 alu_illegal;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 accept;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flag_zero = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf  = ovf_q;
  assign flag_neg  = neg_q;
  assign err       = err_q;

  // Bit WIDTH of diff is the carry-out of a + ~b + 1, i.e. the inverse of borrow.
  always_comb begin
    sum         = {1'b0, a} + {1'b0, b};
    diff        = {1'b0, a} + {1'b0, ~b} + SUB_ONE;
    borrow      = ~diff[WIDTH];
    add_ovf     = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
    sub_ovf     = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    shamt       = b[SHW-1:0];
    sh_in_range = ({1'b0, shamt} < CNT_INIT);
    sra_res     = $signed(a) >>> shamt;
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = borrow;
        alu_ovf   = sub_ovf;
      end
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, borrow};
      OP_SLL:  alu_res = sh_in_range ? (a << shamt) : '0;
      OP_SRL:  alu_res = sh_in_range ? (a >> shamt) : '0;
      OP_SRA:  alu_res = sh_in_range ? sra_res : {WIDTH{a[WIDTH-1]}};
      OP_MUL:  alu_res = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          err_d = 1'b0;
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CNT_INIT;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            neg_d    = alu_res[WIDTH-1];
            err_d    = alu_illegal;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        // Last iteration: publish straight from the final accumulator sum.
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          result_d = acc_next[WIDTH-1:0];
          zero_d   = (acc_next[WIDTH-1:0] == '0);
          carry_d  = |acc_next[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          neg_d    = acc_next[WIDTH-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : directed vector table plus multi-cycle sequences, WIDTH 4 and 32
// Revision: 1.0
// ============================================================================
module tb_alu_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_ready;
  logic        iv4, iv32;
  logic        sel;

  logic        ir4, ov4, z4, c4, o4, n4, e4;
  logic [3:0]  res4;
  logic        ir32, ov32, z32, c32, o32, n32, e32;
  logic [31:0] res32;

  logic        m_ir, m_ov, m_z, m_c, m_o, m_n, m_e;
  logic [31:0] m_res;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;   // {zero, carry, ovf, neg, err}
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op),
    .a(a[3:0]), .b(b[3:0]), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .flag_zero(z4), .flag_carry(c4), .flag_ovf(o4),
    .flag_neg(n4), .err(e4)
  );

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op),
    .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .flag_zero(z32), .flag_carry(c32), .flag_ovf(o32),
    .flag_neg(n32), .err(e32)
  );

  always_comb begin
    if (sel) begin
      m_ir = ir32; m_ov = ov32; m_res = res32;
      m_z = z32; m_c = c32; m_o = o32; m_n = n32; m_e = e32;
    end else begin
      m_ir = ir4; m_ov = ov4; m_res = {28'b0, res4};
      m_z = z4; m_c = c4; m_o = o4; m_n = n4; m_e = e4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic s, input logic [3:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] rr, input logic [4:0] f);
    vec_t v;
    v.sel = s; v.op = o; v.a = aa; v.b = bb; v.res = rr; v.flags = f;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one transaction, scramble inputs, wait for out_valid, check, drain.
  task automatic run(input vec_t v, input string tag);
    int lat;
    int exp_lat;
    sel = v.sel; op = v.op; a = v.a; b = v.b; out_ready = 1'b0;
    if (v.sel) iv32 = 1'b1; else iv4 = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'b0, m_ir}, 32'd1);
    @(posedge clk);
    #1;
    iv4 = 1'b0; iv32 = 1'b0; op = 4'hE; a = ~v.a; b = ~v.b;
    lat = 1;
    while (!m_ov && lat < 80) begin
      tick();
      lat++;
    end
    exp_lat = (v.op == OP_MUL) ? (v.sel ? 33 : 5) : 1;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, m_res, v.res);
    chk({tag, " flags"}, {27'b0, m_z, m_c, m_o, m_n, m_e}, {27'b0, v.flags});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " drained"}, {31'b0, m_ov}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int lowcnt;
    vec_t v;

    // 4-bit vectors: {zero, carry, ovf, neg, err}
    add_vec(0, OP_ADD,  'h7, 'h1, 'h8, 5'b00110);
    add_vec(0, OP_SUB,  'h2, 'h5, 'hD, 5'b01010);
    add_vec(0, OP_SLT,  'h8, 'h1, 'h1, 5'b00000);
    add_vec(0, OP_SLTU, 'h8, 'h1, 'h0, 5'b10000);
    add_vec(0, 4'hE,    'h3, 'h3, 'h0, 5'b10001);
    add_vec(0, OP_EQ,   'h9, 'h9, 'h1, 5'b00000);
    add_vec(0, OP_NOT,  'h5, 'h0, 'hA, 5'b00010);
    add_vec(0, OP_AND,  'hC, 'hA, 'h8, 5'b00010);
    add_vec(0, OP_OR,   'h5, 'hA, 'hF, 5'b00010);
    add_vec(0, OP_XOR,  'hF, 'hF, 'h0, 5'b10000);
    add_vec(0, OP_SLL,  'h3, 'h2, 'hC, 5'b00010);
    add_vec(0, OP_SRL,  'h8, 'h3, 'h1, 5'b00000);
    add_vec(0, OP_SRA,  'h8, 'h2, 'hE, 5'b00010);
    add_vec(0, OP_MUL,  'h3, 'h5, 'hF, 5'b00010);
    add_vec(0, OP_MUL,  'hF, 'hF, 'h1, 5'b01000);
    add_vec(0, OP_ADD,  'hF, 'h1, 'h0, 5'b11000);
    add_vec(0, OP_SUB,  'h8, 'h1, 'h7, 5'b00100);
    add_vec(0, OP_ADD,  'h8, 'h8, 'h0, 5'b11100);
    add_vec(0, OP_SUB,  'h5, 'h5, 'h0, 5'b10000);
    add_vec(0, OP_EQ,   'h9, 'h8, 'h0, 5'b10000);
    // 32-bit vectors
    add_vec(1, OP_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b00110);
    add_vec(1, OP_SUB,  32'h0, 32'h1, 32'hFFFF_FFFF, 5'b01010);
    add_vec(1, OP_MUL,  32'h1234_5678, 32'h9, 32'hA3D7_0A38, 5'b00010);
    add_vec(1, OP_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5'b00010);
    add_vec(1, OP_SLL,  32'h1, 32'hFFFF_FFE4, 32'h10, 5'b00000);
    add_vec(1, OP_SRL,  32'h8000_0000, 32'h4, 32'h0800_0000, 5'b00000);

    rst = 1'b1; iv4 = 1'b0; iv32 = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset4 outputs", {25'b0, ir4, ov4, z4, c4, o4, n4, e4}, {25'b0, 7'b1000000});
    chk("reset4 result", {28'b0, res4}, 32'd0);
    chk("reset32 outputs", {25'b0, ir32, ov32, z32, c32, o32, n32, e32}, {25'b0, 7'b1000000});
    chk("reset32 result", res32, 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      run(vt[i], $sformatf("vec%0d", i));
    end

    // Back-pressure on an XOR result while an AND waits at the input.
    sel = 1'b0; op = OP_XOR; a = 32'h6; b = 32'h3; iv4 = 1'b1; out_ready = 1'b0;
    tick();
    op = OP_AND; a = 32'hC; b = 32'h6;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold valid %0d", k), {31'b0, m_ov}, 32'd1);
      chk($sformatf("bp hold result %0d", k), m_res, 32'h5);
      chk($sformatf("bp hold ready %0d", k), {31'b0, m_ir}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp release ready", {31'b0, m_ir}, 32'd1);
    tick();
    iv4 = 1'b0;
    chk("bp and valid", {31'b0, m_ov}, 32'd1);
    chk("bp and result", m_res, 32'h4);
    tick();
    out_ready = 1'b0;
    chk("bp idle", {31'b0, m_ov}, 32'd0);

    // Reset in the middle of a 32-bit multiply.
    sel = 1'b1; op = OP_MUL; a = 32'h1234_5678; b = 32'h9; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("mid-mul ready", {31'b0, m_ir}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort valid", {31'b0, m_ov}, 32'd0);
    chk("abort result", m_res, 32'd0);
    chk("abort ready", {31'b0, m_ir}, 32'd1);
    v.sel = 1'b1; v.op = OP_ADD; v.a = 32'd3; v.b = 32'd4; v.res = 32'd7; v.flags = 5'b00000;
    run(v, "post-abort add");

    // Multiply whose low half is zero: 2^16 * 2^17.
    sel = 1'b1; op = OP_MUL; a = 32'h0001_0000; b = 32'h0002_0000; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    lat = 1; lowcnt = 0;
    while (!m_ov && lat < 80) begin
      if (!m_ir) lowcnt++;
      tick();
      lat++;
    end
    chk("mul32 latency", lat, 33);
    chk("mul32 busy cycles", lowcnt, 32);
    chk("mul32 result", m_res, 32'd0);
    chk("mul32 flags", {27'b0, m_z, m_c, m_o, m_n, m_e}, {27'b0, 5'b11000});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
